// File: rtl/ps2_key_cmd.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_cmd
// Brief    : PS/2 key events to registered game command pulses, with typematic
//            suppression, left/right/down auto-repeat and player swap routing.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_cmd #(
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter int CNT_W         = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] key_event,
    input  logic        swap,
    output logic        p1_up,
    output logic        p1_down,
    output logic        p1_left,
    output logic        p1_right,
    output logic        p2_up,
    output logic        p2_down,
    output logic        p2_left,
    output logic        p2_right,
    output logic        boom1,
    output logic        boom2,
    output logic        pause,
    output logic        space,
    output logic        reset_req
);

    localparam logic [1:0]       c_S_IDLE   = 2'd0;
    localparam logic [1:0]       c_S_DELAY  = 2'd1;
    localparam logic [1:0]       c_S_REPEAT = 2'd2;
    localparam logic [CNT_W-1:0] c_DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] c_PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

    // Key index: 0 W, 1 A, 2 S, 3 D, 4 P, 5 Space, 6 R, 7 boom1,
    //            8 up, 9 left, 10 down, 11 right, 12 boom2
    logic        w_ext;
    logic        w_brk;
    logic [12:0] w_hit;
    logic [12:0] w_make;
    logic [12:0] w_break;
    logic [12:0] w_pulse;
    logic [12:0] r_held;

    logic [1:0][2:0] w_gmk;
    logic [1:0][2:0] w_gbrk;
    logic [1:0][2:0] w_grep;

    assign w_ext = key_event[9];
    assign w_brk = key_event[8];

    always_comb begin
        w_hit = '0;
        if (key_event[10]) begin
            case (key_event[7:0])
                8'h1D:   w_hit[0]  = !w_ext;
                8'h1C:   w_hit[1]  = !w_ext;
                8'h1B:   w_hit[2]  = !w_ext;
                8'h23:   w_hit[3]  = !w_ext;
                8'h4D:   w_hit[4]  = !w_ext;
                8'h29:   w_hit[5]  = !w_ext;
                8'h2D:   w_hit[6]  = !w_ext;
                8'h16:   w_hit[7]  = !w_ext;
                8'h75:   w_hit[8]  = w_ext;
                8'h6B:   w_hit[9]  = w_ext;
                8'h72:   w_hit[10] = w_ext;
                8'h74:   w_hit[11] = w_ext;
                8'h69:   w_hit[12] = 1'b1;
                default: w_hit     = '0;
            endcase
        end
    end

    // A make is only accepted for a key not already held (typematic filter)
    assign w_make  = w_hit & ~r_held & {13{~w_brk}};
    assign w_break = w_hit & {13{w_brk}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_held <= '0;
        end else begin
            r_held <= (r_held | w_make) & ~w_break;
        end
    end

    // Repeatable keys per group, ordered {right, down, left}
    assign w_gmk[0]  = w_make[3:1];
    assign w_gmk[1]  = w_make[11:9];
    assign w_gbrk[0] = w_break[3:1];
    assign w_gbrk[1] = w_break[11:9];

    generate
        for (genvar g = 0; g < 2; g++) begin : g_grp
            logic [1:0]       r_state;
            logic [CNT_W-1:0] r_cnt;
            logic [2:0]       r_akey;
            logic             w_restart;
            logic             w_stop;
            logic             w_last;

            assign w_restart = (|w_gmk[g]) &&
                               ((r_state == c_S_IDLE) || (|(w_gmk[g] & ~r_akey)));
            assign w_stop    = (r_state != c_S_IDLE) && (|(w_gbrk[g] & r_akey));
            assign w_last    = ((r_state == c_S_DELAY)  && (r_cnt == c_DLY_LAST)) ||
                               ((r_state == c_S_REPEAT) && (r_cnt == c_PER_LAST));
            // A key change or release in the same cycle wins over a due repeat
            assign w_grep[g] = (w_last && !w_restart && !w_stop) ? r_akey : 3'b000;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state <= c_S_IDLE;
                    r_cnt   <= '0;
                    r_akey  <= '0;
                end else if (w_restart) begin
                    r_state <= c_S_DELAY;
                    r_cnt   <= '0;
                    r_akey  <= w_gmk[g];
                end else if (w_stop) begin
                    r_state <= c_S_IDLE;
                    r_cnt   <= '0;
                end else begin
                    case (r_state)
                        c_S_DELAY: begin
                            if (r_cnt == c_DLY_LAST) begin
                                r_state <= c_S_REPEAT;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + c_ONE;
                            end
                        end
                        c_S_REPEAT: begin
                            if (r_cnt == c_PER_LAST) begin
                                r_cnt <= '0;
                            end else begin
                                r_cnt <= r_cnt + c_ONE;
                            end
                        end
                        default: begin
                            r_state <= c_S_IDLE;
                            r_cnt   <= '0;
                        end
                    endcase
                end
            end
        end
    endgenerate

    assign w_pulse = w_make | {1'b0, w_grep[1], 5'b00000, w_grep[0], 1'b0};

    // swap=0: WASD -> player 1, arrows -> player 2; swap=1 reverses it
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_up     <= 1'b0;
            p1_down   <= 1'b0;
            p1_left   <= 1'b0;
            p1_right  <= 1'b0;
            p2_up     <= 1'b0;
            p2_down   <= 1'b0;
            p2_left   <= 1'b0;
            p2_right  <= 1'b0;
            boom1     <= 1'b0;
            boom2     <= 1'b0;
            pause     <= 1'b0;
            space     <= 1'b0;
            reset_req <= 1'b0;
        end else begin
            p1_up     <= swap ? w_pulse[8]  : w_pulse[0];
            p1_left   <= swap ? w_pulse[9]  : w_pulse[1];
            p1_down   <= swap ? w_pulse[10] : w_pulse[2];
            p1_right  <= swap ? w_pulse[11] : w_pulse[3];
            p2_up     <= swap ? w_pulse[0]  : w_pulse[8];
            p2_left   <= swap ? w_pulse[1]  : w_pulse[9];
            p2_down   <= swap ? w_pulse[2]  : w_pulse[10];
            p2_right  <= swap ? w_pulse[3]  : w_pulse[11];
            boom1     <= w_pulse[7];
            boom2     <= w_pulse[12];
            pause     <= w_pulse[4];
            space     <= w_pulse[5];
            reset_req <= w_pulse[6];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_cmd.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_key_cmd
// Brief    : Scoreboard bench for ps2_key_cmd against a timestamp-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_cmd;

    localparam int RD = 8;
    localparam int RP = 4;

    logic        clk;
    logic        rst;
    logic [10:0] key_event;
    logic        swap;
    logic p1_up, p1_down, p1_left, p1_right;
    logic p2_up, p2_down, p2_left, p2_right;
    logic boom1, boom2, pause, space, reset_req;

    ps2_key_cmd #(.REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .key_event(key_event), .swap(swap),
        .p1_up(p1_up), .p1_down(p1_down), .p1_left(p1_left), .p1_right(p1_right),
        .p2_up(p2_up), .p2_down(p2_down), .p2_left(p2_left), .p2_right(p2_right),
        .boom1(boom1), .boom2(boom2), .pause(pause), .space(space),
        .reset_req(reset_req)
    );

    // Output vector: 0..3 p1 up/down/left/right, 4..7 p2 up/down/left/right,
    // 8 boom1, 9 boom2, 10 pause, 11 space, 12 reset_req
    logic [12:0] dut_v;
    assign dut_v = {reset_req, space, pause, boom2, boom1,
                    p2_right, p2_left, p2_down, p2_up,
                    p1_right, p1_left, p1_down, p1_up};

    typedef struct {
        int          due;
        logic [12:0] v;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   p1_left_cnt = 0;
    int   rreq_cnt = 0;

    // Model state: held keys, per-group active key and its make cycle
    int   codes[13]   = '{'h1D, 'h1C, 'h1B, 'h23, 'h4D, 'h29, 'h2D, 'h16,
                          'h75, 'h6B, 'h72, 'h74, 'h69};
    int   ext_req[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 2};
    bit [12:0] m_held = '0;
    int   m_act[2]   = '{-1, -1};
    int   m_start[2] = '{0, 0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int key_of(input logic [7:0] code, input logic ext);
        for (int i = 0; i < 13; i++)
            if (codes[i] == int'(code) && (ext_req[i] == 2 || ext_req[i] == int'(ext)))
                return i;
        return -1;
    endfunction

    function automatic int grp_of(input int k);
        if (k >= 1 && k <= 3) return 0;
        if (k >= 9 && k <= 11) return 1;
        return -1;
    endfunction

    function automatic int out_idx(input int k, input logic sw);
        int dir;
        bit p2;
        case (k)
            7:  return 8;
            12: return 9;
            4:  return 10;
            5:  return 11;
            6:  return 12;
            default: ;
        endcase
        if (k == 0 || k == 8)       dir = 0;
        else if (k == 2 || k == 10) dir = 1;
        else if (k == 1 || k == 9)  dir = 2;
        else                        dir = 3;
        p2 = (k < 4) ? sw : !sw;
        return (p2 ? 4 : 0) + dir;
    endfunction

    function automatic logic [12:0] model(input logic [10:0] ev, input logic sw,
                                          input logic r, input int c);
        logic [12:0] o;
        int k, g, d;
        bit cancel[2];
        o = '0;
        cancel[0] = 1'b0;
        cancel[1] = 1'b0;
        if (r) begin
            m_held = '0;
            m_act[0] = -1;
            m_act[1] = -1;
            return o;
        end
        k = ev[10] ? key_of(ev[7:0], ev[9]) : -1;
        if (k >= 0) begin
            g = grp_of(k);
            if (ev[8]) begin
                m_held[k] = 1'b0;
                if (g >= 0 && m_act[g] == k) begin
                    m_act[g] = -1;
                    cancel[g] = 1'b1;
                end
            end else if (!m_held[k]) begin
                m_held[k] = 1'b1;
                o[out_idx(k, sw)] = 1'b1;
                if (g >= 0) begin
                    m_act[g] = k;
                    m_start[g] = c;
                    cancel[g] = 1'b1;
                end
            end
        end
        // Repeat outputs land at make+1+RD+n*RP, i.e. decided at make+RD+n*RP
        for (int gi = 0; gi < 2; gi++) begin
            if (m_act[gi] >= 0 && !cancel[gi]) begin
                d = c - m_start[gi] - RD;
                if (d >= 0 && (d % RP) == 0) o[out_idx(m_act[gi], sw)] = 1'b1;
            end
        end
        return o;
    endfunction

    task automatic step(input logic [10:0] ev, input logic sw, input logic r);
        exp_t e;
        key_event = ev;
        swap      = sw;
        rst       = r;
        e.due = cyc + 1;
        e.v   = model(ev, sw, r, cyc);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (p1_left === 1'b1) p1_left_cnt++;
        if (reset_req === 1'b1) rreq_cnt++;
        if (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            checks++;
            if (dut_v !== e.v || e.due != cyc) begin
                errors++;
                $display("FAIL outputs cyc=%0d due=%0d got=%b exp=%b", cyc, e.due, dut_v, e.v);
            end
        end
    end

    initial begin
        logic [10:0] ev;
        logic        sw;
        logic        r;
        logic [7:0]  code;
        logic        ext;
        int          idx;
        int          roll;

        key_event = '0;
        swap = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(11'h000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(11'h000, 1'b0, 1'b0);

        // A held with typematic makes, then released
        p1_left_cnt = 0;
        step(11'h41C, 1'b0, 1'b0);
        for (int i = 1; i <= 18; i++)
            step((i == 2 || i == 4) ? 11'h41C : 11'h000, 1'b0, 1'b0);
        step(11'h51C, 1'b0, 1'b0);
        checks++;
        if (p1_left_cnt != 4) begin
            errors++;
            $display("FAIL hold_A_pulses got=%0d exp=4", p1_left_cnt);
        end
        for (int i = 0; i < 12; i++) step(11'h000, 1'b0, 1'b0);

        // Up arrow: wrong extended flag ignored, then accepted, no repeat
        step(11'h475, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(11'h000, 1'b0, 1'b0);
        step(11'h675, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) step(11'h000, 1'b0, 1'b0);
        step(11'h775, 1'b0, 1'b0);

        // D held with swap, swap dropped mid-hold
        step(11'h423, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(11'h000, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(11'h000, 1'b0, 1'b0);
        step(11'h523, 1'b0, 1'b0);

        // A then D: the newer key takes over the repeat
        step(11'h41C, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(11'h000, 1'b0, 1'b0);
        step(11'h423, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) step(11'h000, 1'b0, 1'b0);
        step(11'h51C, 1'b0, 1'b0);
        step(11'h523, 1'b0, 1'b0);

        // R pressed, reset while held, R typematic treated as new
        rreq_cnt = 0;
        step(11'h42D, 1'b0, 1'b0);
        step(11'h000, 1'b0, 1'b0);
        step(11'h000, 1'b0, 1'b1);
        step(11'h000, 1'b0, 1'b0);
        step(11'h42D, 1'b0, 1'b0);
        step(11'h000, 1'b0, 1'b0);
        step(11'h000, 1'b0, 1'b0);
        checks++;
        if (rreq_cnt != 2) begin
            errors++;
            $display("FAIL reset_req_pulses got=%0d exp=2", rreq_cnt);
        end
        step(11'h52D, 1'b0, 1'b0);

        sw = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 3) sw = !sw;
            r = ($urandom_range(0, 199) == 0);
            roll = $urandom_range(0, 99);
            if (roll < 12) begin
                idx = $urandom_range(0, 14);
                if (idx < 13) begin
                    code = 8'(codes[idx]);
                    if (ext_req[idx] == 2) ext = 1'($urandom);
                    else ext = ($urandom_range(0, 7) == 0) ? (ext_req[idx] == 0)
                                                           : (ext_req[idx] == 1);
                end else begin
                    code = 8'($urandom);
                    ext  = 1'($urandom);
                end
                ev = {1'b1, ext, ($urandom_range(0, 99) < 45), code};
            end else if (roll < 20) begin
                ev = {1'b0, 10'($urandom)};
            end else begin
                ev = 11'h000;
            end
            step(ev, sw, r);
        end

        step(11'h000, sw, 1'b0);
        step(11'h000, sw, 1'b0);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
